stage_mem: RTL

STAGE_MEM -- requirements
Module: stage_mem

---
 rtl/stage_mem.sv | 127 ++++++++++++
 1 files changed

// File: rtl/stage_mem.sv
// stage_mem: pipeline memory stage; issues one data-memory request per load/store and
// stalls upstream until dmAck, then registers write-back values.
// Optional feature: define MEM_MISALIGN_TRAP_EN to trap misaligned H/W accesses
// (misalignOut port); otherwise the address is forced to natural alignment.
module stage_mem (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [4:0]  memOpIn,
    input  logic [7:0]  wdOpIn,
    input  logic [31:0] exResultIn,
    input  logic [31:0] regData2In,
    input  logic [31:0] pcPlusIn,
    input  logic [31:0] immIn,
    output logic        dmReq,
    output logic        dmWe,
    output logic [31:0] dmAddr,
    output logic [31:0] dmWdata,
    output logic [3:0]  dmBe,
    input  logic [31:0] dmRdata,
    input  logic        dmAck,
    output logic        stallOut,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic        misalignOut,
`endif
    output logic [7:0]  wdOpOut,
    output logic [31:0] exResultOut,
    output logic [31:0] memDataOut,
    output logic [31:0] pcPlusOut,
    output logic [31:0] immOut
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t r_state, w_next;
    logic        r_we, r_kill;
    logic [1:0]  r_lo;
    logic [2:0]  r_size;
    logic [3:0]  r_be;
    logic [7:0]  r_wd;
    logic [31:0] r_addr, r_wdata, r_ex, r_pc, r_imm;
    logic        w_is_b, w_is_h, w_mis, w_start, w_issue, w_pass, w_load;
    logic        w_r_is_b, w_r_is_h;
    logic [1:0]  w_off, w_lo;
    logic [3:0]  w_be;
    logic [31:0] w_wdata, w_lane, w_rdata;

    assign w_is_b  = memOpIn[3:2] == 2'b00;
    assign w_is_h  = memOpIn[3:2] == 2'b01;
    assign w_off   = exResultIn[1:0];
    assign w_lo    = w_is_b ? w_off : w_is_h ? {w_off[1], 1'b0} : 2'b00;
`ifdef MEM_MISALIGN_TRAP_EN
    assign w_mis   = (w_is_h & w_off[0]) | (!w_is_b & !w_is_h & (|w_off));
`else
    assign w_mis   = 1'b0;
`endif
    assign w_start = (r_state == IDLE) & memOpIn[0] & !flush;
    assign w_issue = w_start & !w_mis;
    assign w_pass  = (r_state == IDLE) & !memOpIn[0] & !flush;
    assign w_load  = (r_state == BUSY) & dmAck & !r_kill & !flush;
    assign w_wdata = !memOpIn[1] ? 32'h0 : w_is_b ? {4{regData2In[7:0]}} :
                     w_is_h ? {2{regData2In[15:0]}} : regData2In;
    assign w_be    = !memOpIn[1] ? 4'hF : w_is_b ? 4'b0001 << w_lo :
                     w_is_h ? 4'b0011 << w_lo : 4'hF;
    assign w_r_is_b = r_size[1:0] == 2'b00;
    assign w_r_is_h = r_size[1:0] == 2'b01;
    assign w_lane  = dmRdata >> {r_lo, 3'b000};
    assign w_rdata = r_we ? 32'h0 :
                     w_r_is_b ? (r_size[2] ? {24'h0, w_lane[7:0]} : {{24{w_lane[7]}}, w_lane[7:0]}) :
                     w_r_is_h ? (r_size[2] ? {16'h0, w_lane[15:0]} : {{16{w_lane[15]}}, w_lane[15:0]}) :
                     dmRdata;

    assign dmReq    = r_state == BUSY;
    assign dmWe     = r_we;
    assign dmAddr   = r_addr;
    assign dmWdata  = r_wdata;
    assign dmBe     = r_be;
    assign stallOut = rst & (w_issue | ((r_state == BUSY) & !dmAck));

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    // next state: issue moves to BUSY, acknowledge returns to IDLE
    always_comb begin
        w_next = r_state;
        if (r_state == IDLE && w_issue) w_next = BUSY;
        if (r_state == BUSY && dmAck)   w_next = IDLE;
    end

    // capture the bus request and the instruction fields held across BUSY
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr <= '0; r_wdata <= '0; r_be <= '0; r_we <= 1'b0; r_lo <= '0; r_size <= '0;
            r_wd <= '0; r_ex <= '0; r_pc <= '0; r_imm <= '0; r_kill <= 1'b0;
        end else if (w_issue) begin
            r_addr <= {exResultIn[31:2], 2'b00}; r_wdata <= w_wdata; r_be <= w_be;
            r_we <= memOpIn[1]; r_lo <= w_lo; r_size <= memOpIn[4:2];
            r_wd <= wdOpIn; r_ex <= exResultIn; r_pc <= pcPlusIn; r_imm <= immIn; r_kill <= 1'b0;
        end else if (r_state == BUSY && flush) begin
            r_kill <= 1'b1;
        end
    end

    // write-back registers: pass-through, completed memory result, or bubble
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdOpOut <= '0; exResultOut <= '0; memDataOut <= '0; pcPlusOut <= '0; immOut <= '0;
        end else if (w_pass) begin
            wdOpOut <= wdOpIn; exResultOut <= exResultIn; memDataOut <= '0;
            pcPlusOut <= pcPlusIn; immOut <= immIn;
        end else if (w_load) begin
            wdOpOut <= r_wd; exResultOut <= r_ex; memDataOut <= w_rdata;
            pcPlusOut <= r_pc; immOut <= r_imm;
        end else begin
            wdOpOut <= '0; exResultOut <= '0; memDataOut <= '0; pcPlusOut <= '0; immOut <= '0;
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    // one-cycle trap flag alongside the bubble
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) misalignOut <= 1'b0;
        else      misalignOut <= w_start & w_mis;
    end
`endif
endmodule
